// File: rtl/service_pkg.sv
// Shared types and defaults for the service requester: FSM state encoding,
// bus widths and the saturating serve-count helper.
package service_pkg;

    localparam int unsigned INIT_PW_DEF  = 2;
    localparam int unsigned OPEN_TMO_DEF = 16;
    localparam int unsigned LEN_W        = 8;
    localparam int unsigned TMR_W        = 8;

    localparam logic [LEN_W-1:0] SERVE_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT_OPEN,
        SERVE,
        CLOSE
    } sr_state_e;

    // Increment that sticks at SERVE_MAX instead of wrapping.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == SERVE_MAX) ? v : v + LEN_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the window status line; only compiled when
// SR_SYNC_EN is defined, since the requester instantiates it only then.
`ifdef SR_SYNC_EN
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`endif

// File: rtl/service_requester.sv
// Client-side requester: accepts a request, pulses INIT to the service window,
// grants while the window is open and reports the served cycle count.
// Define SR_SYNC_EN to pass SW_STAT through a 2-flop synchronizer first.
module service_requester
    import service_pkg::*;
#(
    parameter int unsigned INIT_PW  = INIT_PW_DEF,
    parameter int unsigned OPEN_TMO = OPEN_TMO_DEF
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             REQ,
    input  logic [LEN_W-1:0] REQ_LEN,
    output logic             ACK,
    output logic             INIT,
    output logic [LEN_W-1:0] SWLEN,
    input  logic             SW_STAT,
    output logic             GRANT,
    output logic             DONE,
    output logic             TIMEOUT,
    output logic [LEN_W-1:0] SERVED,
    output logic             BUSY
);

    logic sw_stat_s;

`ifdef SR_SYNC_EN
    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk_i  (CLK),
        .rst_n_i(RSTN),
        .d_i    (SW_STAT),
        .q_o    (sw_stat_s)
    );
`else
    assign sw_stat_s = SW_STAT;
`endif

    sr_state_e        state_q;
    logic             ack_q;
    logic             init_q;
    logic [LEN_W-1:0] swlen_q;
    logic             grant_q;
    logic             done_q;
    logic             timeout_q;
    logic [LEN_W-1:0] served_q;
    logic             busy_q;
    logic [TMR_W-1:0] tmr_q;
    logic [LEN_W-1:0] serve_cnt_q;

    // Shared timer counts INIT pulse width in PULSE and open wait in WAIT_OPEN.
    // The serve counter starts at 1 so it equals GRANT-high cycles at close.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            init_q      <= 1'b1;
            swlen_q     <= '0;
            grant_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            served_q    <= '0;
            busy_q      <= 1'b0;
            tmr_q       <= '0;
            serve_cnt_q <= '0;
        end else begin
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (REQ) begin
                        ack_q  <= 1'b1;
                        busy_q <= 1'b1;
                        tmr_q  <= '0;
                        if (REQ_LEN != '0) begin
                            swlen_q <= REQ_LEN;
                            init_q  <= 1'b0;
                            state_q <= PULSE;
                        end else begin
                            served_q <= '0;
                            state_q  <= CLOSE;
                        end
                    end
                end
                PULSE: begin
                    if (tmr_q == TMR_W'(INIT_PW - 1)) begin
                        init_q  <= 1'b1;
                        tmr_q   <= '0;
                        state_q <= WAIT_OPEN;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                WAIT_OPEN: begin
                    if (!sw_stat_s) begin
                        grant_q     <= 1'b1;
                        serve_cnt_q <= LEN_W'(1);
                        state_q     <= SERVE;
                    end else if (tmr_q == TMR_W'(OPEN_TMO - 1)) begin
                        timeout_q <= 1'b1;
                        served_q  <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                SERVE: begin
                    if (sw_stat_s) begin
                        grant_q  <= 1'b0;
                        served_q <= serve_cnt_q;
                        state_q  <= CLOSE;
                    end else begin
                        serve_cnt_q <= sat_inc(serve_cnt_q);
                    end
                end
                CLOSE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ACK     = ack_q;
    assign INIT    = init_q;
    assign SWLEN   = swlen_q;
    assign GRANT   = grant_q;
    assign DONE    = done_q;
    assign TIMEOUT = timeout_q;
    assign SERVED  = served_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_service_requester.sv
// Scoreboard bench for service_requester with a behavioural service-window model.
module tb_service_requester;

    localparam int TB_INIT_PW  = 2;
    localparam int TB_OPEN_TMO = 16;

    logic       CLK;
    logic       RSTN;
    logic       REQ;
    logic [7:0] REQ_LEN;
    logic       ACK;
    logic       INIT;
    logic [7:0] SWLEN;
    logic       SW_STAT;
    logic       GRANT;
    logic       DONE;
    logic       TIMEOUT;
    logic [7:0] SERVED;
    logic       BUSY;

    service_requester #(
        .INIT_PW (TB_INIT_PW),
        .OPEN_TMO(TB_OPEN_TMO)
    ) dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .REQ    (REQ),
        .REQ_LEN(REQ_LEN),
        .ACK    (ACK),
        .INIT   (INIT),
        .SWLEN  (SWLEN),
        .SW_STAT(SW_STAT),
        .GRANT  (GRANT),
        .DONE   (DONE),
        .TIMEOUT(TIMEOUT),
        .SERVED (SERVED),
        .BUSY   (BUSY)
    );

    typedef struct {
        bit zero_len;
        bit is_tmo;
        int served;
        int grant;
    } comp_t;

    typedef struct {
        int d;
        int lovr;
    } cfg_t;

    comp_t comp_q[$];
    int    ack_q[$];
    cfg_t  cfg_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event absent or unexpected (cycle %0d)", name, cyc);
    endtask

    // sel: 0=ACK 1=BUSY low 2=GRANT 3=DONE
    task automatic wait_for(input string name, input int sel, input int budget);
        int  n;
        bit  hit;
        n = 0;
        forever begin
            @(posedge CLK);
            #1;
            case (sel)
                0:       hit = ACK;
                1:       hit = !BUSY;
                2:       hit = GRANT;
                default: hit = DONE;
            endcase
            if (hit) break;
            n++;
            if (n >= budget) begin
                fail_now(name);
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Expected outcome from the window's behaviour: closed for d edges, then open for L.
    task automatic push_expect(input int len, input int d, input int lovr);
        comp_t c;
        cfg_t  w;
        int    l;
        ack_q.push_back(len);
        l = (lovr != 0) ? lovr : len + 1;
        c.zero_len = (len == 0);
        c.is_tmo   = (len != 0) && (d >= TB_OPEN_TMO);
        c.served   = (c.zero_len || c.is_tmo) ? 0 : ((l > 255) ? 255 : l);
        c.grant    = (c.zero_len || c.is_tmo) ? 0 : l;
        comp_q.push_back(c);
        if (len != 0) begin
            w.d    = d;
            w.lovr = lovr;
            cfg_q.push_back(w);
        end
    endtask

    task automatic run_txn(input int len, input int d, input int lovr);
        push_expect(len, d, lovr);
        REQ     = 1'b1;
        REQ_LEN = 8'(len);
        wait_for("ack_wait", 0, 100);
        REQ = 1'b0;
        wait_for("idle_wait", 1, 2000);
    endtask

    // Service window model: reacts to INIT rising like the real window block.
    int  win_k, w_d, w_l;
    bit  win_on;
    bit  prev_init_w;
    initial begin
        cfg_t c;
        SW_STAT     = 1'b1;
        win_on      = 1'b0;
        prev_init_w = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (!RSTN) begin
                win_on      = 1'b0;
                SW_STAT     = 1'b1;
                prev_init_w = 1'b1;
            end else begin
                if (!prev_init_w && INIT) begin
                    if (cfg_q.size() > 0) begin
                        c   = cfg_q.pop_front();
                        w_d = c.d;
                        w_l = (c.lovr != 0) ? c.lovr : int'(SWLEN) + 1;
                    end else begin
                        w_d = 100000;
                        w_l = 0;
                    end
                    win_k  = 0;
                    win_on = 1'b1;
                end
                prev_init_w = INIT;
                if (win_on) begin
                    win_k++;
                    if (win_k <= w_d) SW_STAT = 1'b1;
                    else if (win_k <= w_d + w_l) SW_STAT = 1'b0;
                    else begin
                        SW_STAT = 1'b1;
                        win_on  = 1'b0;
                    end
                end else begin
                    SW_STAT = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents ACK or DONE/TIMEOUT.
    initial begin
        bit    prev_ack, prev_done, prev_tmo, prev_init;
        bit    init_low_any, swlen_chg;
        int    cur_len, ack_cyc, init_rise_cyc, init_low_run, grant_run, l;
        comp_t e;
        prev_ack = 0; prev_done = 0; prev_tmo = 0; prev_init = 1;
        init_low_any = 0; swlen_chg = 0; cur_len = 0; ack_cyc = 0;
        init_rise_cyc = 0; init_low_run = 0; grant_run = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RSTN) begin
                prev_ack = 0; prev_done = 0; prev_tmo = 0; prev_init = 1;
                init_low_run = 0; grant_run = 0; cur_len = 0;
                continue;
            end
            if (ACK) begin
                check("ack_single_cycle", prev_ack, 0);
                if (ack_q.size() == 0) fail_now("ack_unexpected");
                else begin
                    l       = ack_q.pop_front();
                    cur_len = l;
                    if (l != 0) check("swlen_at_ack", SWLEN, l);
                end
                ack_cyc      = cyc;
                init_low_any = 0;
                grant_run    = 0;
                swlen_chg    = 0;
            end else if (BUSY && cur_len != 0 && int'(SWLEN) != cur_len) begin
                swlen_chg = 1;
            end
            if (!INIT) begin
                init_low_run++;
                init_low_any = 1;
            end else if (!prev_init) begin
                check("init_low_width", init_low_run, TB_INIT_PW);
                init_rise_cyc = cyc;
                init_low_run  = 0;
            end
            if (GRANT) grant_run++;
            if (DONE || TIMEOUT) begin
                check("done_timeout_exclusive", DONE && TIMEOUT, 0);
                check("pulse_single_cycle", (DONE && prev_done) || (TIMEOUT && prev_tmo), 0);
                if (comp_q.size() == 0) fail_now("completion_unexpected");
                else begin
                    e = comp_q.pop_front();
                    check("timeout_flag", TIMEOUT, e.is_tmo);
                    check("served", SERVED, e.served);
                    check("grant_cycles", grant_run, e.grant);
                    check("grant_low_at_end", GRANT, 0);
                    check("swlen_stable", swlen_chg, 0);
                    if (e.zero_len) begin
                        check("zero_len_done_latency", cyc - ack_cyc, 1);
                        check("zero_len_init_idle", init_low_any, 0);
                    end
                    if (e.is_tmo) check("timeout_latency", cyc - init_rise_cyc, TB_OPEN_TMO);
                end
            end
            prev_ack  = ACK;
            prev_done = DONE;
            prev_tmo  = TIMEOUT;
            prev_init = INIT;
        end
    end

    // Stimulus
    initial begin
        int len, d, lovr, done_cyc;
        RSTN    = 1'b0;
        REQ     = 1'b0;
        REQ_LEN = 8'd0;
        idle_cycles(3);
        check("rst_ack", ACK, 0);
        check("rst_init", INIT, 1);
        check("rst_swlen", SWLEN, 0);
        check("rst_grant", GRANT, 0);
        check("rst_done", DONE, 0);
        check("rst_timeout", TIMEOUT, 0);
        check("rst_served", SERVED, 0);
        check("rst_busy", BUSY, 0);
        RSTN = 1'b1;
        idle_cycles(2);

        run_txn(5, 1, 0);
        run_txn(0, 0, 0);
        run_txn(8, 100000, 0);
        run_txn(4, 15, 0);
        run_txn(4, 16, 0);

        // Reset while serving: no completion is expected afterwards.
        ack_q.push_back(10);
        begin
            cfg_t w;
            w.d = 2; w.lovr = 40;
            cfg_q.push_back(w);
        end
        REQ = 1'b1; REQ_LEN = 8'd10;
        wait_for("rst_serve_ack", 0, 100);
        REQ = 1'b0;
        wait_for("rst_serve_grant", 2, 100);
        idle_cycles(3);
        RSTN = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_serve_grant_low", GRANT, 0);
        check("rst_serve_init_high", INIT, 1);
        check("rst_serve_busy_low", BUSY, 0);
        check("rst_serve_done_low", DONE, 0);
        check("rst_serve_served", SERVED, 0);
        check("rst_serve_swlen", SWLEN, 0);
        #2;
        RSTN = 1'b1;
        idle_cycles(50);

        // REQ held through DONE: second ACK right after, SWLEN changes only then.
        push_expect(4, 0, 0);
        REQ = 1'b1; REQ_LEN = 8'd4;
        wait_for("held_ack1", 0, 100);
        REQ_LEN = 8'd7;
        push_expect(7, 3, 0);
        wait_for("held_done1", 3, 200);
        done_cyc = cyc;
        wait_for("held_ack2", 0, 100);
        check("held_ack2_latency", cyc - done_cyc, 1);
        check("held_swlen_updated", SWLEN, 7);
        REQ = 1'b0;
        wait_for("held_idle", 1, 2000);

        run_txn(3, 0, 300);
        run_txn(255, 0, 0);

        for (int i = 0; i < 30; i++) begin
            len  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            d    = int'($urandom_range(0, 20));
            lovr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : 0;
            run_txn(len, d, lovr);
            idle_cycles(int'($urandom_range(0, 3)));
        end

        idle_cycles(5);
        check("scoreboard_drained", comp_q.size() + ack_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/service_requester.md
SERVICE_REQUESTER -- requirements
Module: service_requester

Interface
REQ-001 Parameters SHALL be INIT_PW (default 2), the INIT low-pulse width in cycles (legal range 1-15), and OPEN_TMO (default 16), the maximum number of cycles to wait for the window to open (legal range 1-255).
REQ-002 Port CLK  in  1: single system clock; all state SHALL update on its rising edge.
REQ-003 Port RSTN  in  1: reset, synchronous, active-low.
REQ-004 Port REQ  in  1: service request, held high by the client until ACK.
REQ-005 Port REQ_LEN  in  8: requested window length, sampled on the ACK cycle.
REQ-006 Port ACK  out  1: one-cycle request-accepted pulse.
REQ-007 Port INIT  out  1: active-low window-open pulse to the service window block; idle value is 1.
REQ-008 Port SWLEN  out  8: window length presented to the service window block.
REQ-009 Port SW_STAT  in  1: window status from the service window block; 0 means open, 1 means closed.
REQ-010 Port GRANT  out  1: high while the client may use the window.
REQ-011 Port DONE  out  1: one-cycle pulse on normal window close.
REQ-012 Port TIMEOUT  out  1: one-cycle pulse when the window fails to open.
REQ-013 Port SERVED  out  8: count of GRANT-high cycles from the last window, latched at close.
REQ-014 Port BUSY  out  1: high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, PULSE, WAIT_OPEN, SERVE, CLOSE.
REQ-016 IDLE with REQ=1 and REQ_LEN!=0: at the next edge, ACK=1, SWLEN<=REQ_LEN, INIT<=0, and the state moves to PULSE.
REQ-017 IDLE with REQ=1 and REQ_LEN=0: at the next edge, ACK=1 and the state moves to CLOSE; INIT stays 1 and SERVED is cleared to 0.
REQ-018 PULSE SHALL hold INIT=0 for exactly INIT_PW cycles, then drive INIT=1 and move to WAIT_OPEN.
REQ-019 WAIT_OPEN: sampled SW_STAT=0 moves to SERVE with GRANT=1 at that edge.
REQ-020 WAIT_OPEN: after OPEN_TMO cycles with SW_STAT=1, the block SHALL pulse TIMEOUT, clear SERVED, and return to IDLE.
REQ-021 SERVE: GRANT stays 1 and an 8-bit serve counter increments each cycle while sampled SW_STAT=0.
REQ-022 The serve counter SHALL saturate at 255 and never wrap.
REQ-023 SERVE: sampled SW_STAT=1 drops GRANT at that edge, latches the counter into SERVED, and moves to CLOSE.
REQ-024 CLOSE SHALL last one cycle with DONE=1, then return to IDLE.
REQ-025 REQ while BUSY=1 SHALL be ignored (no ACK); it is accepted in the first IDLE cycle in which it is still high.
REQ-026 SWLEN SHALL remain stable from ACK until the block returns to IDLE.
REQ-027 ACK, DONE and TIMEOUT SHALL never be high for more than one consecutive cycle.
REQ-028 DONE and TIMEOUT SHALL be mutually exclusive.

Reset
REQ-029 RSTN=0 at a rising CLK edge SHALL force IDLE, INIT=1, SWLEN=0, ACK=GRANT=DONE=TIMEOUT=BUSY=0, SERVED=0, and clear all counters.
REQ-030 Reset SHALL apply from any state, including mid-PULSE (INIT returns to 1) and mid-SERVE (GRANT drops and no DONE is issued).

Configuration
REQ-031 With SR_SYNC_EN defined, SW_STAT SHALL pass through a 2-flop synchronizer (reset value 1) before FSM use, which adds 2 cycles to open and close detection.
REQ-032 Without SR_SYNC_EN, SW_STAT SHALL be sampled directly by the FSM.

Structure
REQ-033 The state encoding type and the INIT_PW and OPEN_TMO defaults SHALL live in a shared package, service_pkg.
REQ-034 The synchronizer SHALL be a separate sub-module, sync_2ff, instantiated only under SR_SYNC_EN.

Verification
REQ-035 A bench connected to service_window, with REQ=1 and REQ_LEN=5: ACK one cycle, INIT low 2 cycles, GRANT high, DONE pulse, SERVED=6.
REQ-036 REQ_LEN=0: ACK, then DONE on the next cycle; INIT never goes low and SERVED=0.
REQ-037 SW_STAT tied to 1, REQ_LEN=8: TIMEOUT pulses exactly 16 cycles after WAIT_OPEN entry; GRANT never rises.
REQ-038 RSTN=0 asserted for one cycle during SERVE: next cycle shows IDLE, GRANT=0, INIT=1; no DONE is issued.
REQ-039 REQ held high through DONE: a second ACK occurs in the first IDLE cycle and SWLEN updates only then.
REQ-040 SW_STAT held at 0 for 300 cycles: SERVED=255 after close.
